// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the detection-pulse monitor.
package seq_mon_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  // Increment val by inc, holding at 2^width-1 (width up to 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc,
                                          input int unsigned width);
    logic [32:0] max_val;
    max_val = (33'd1 << width) - 33'd1;
    if (inc && ({1'b0, val} < max_val)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running window cycle counter; pulses o_win_end on the last cycle of each window.
module window_timer #(
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned WINDOW_LEN = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_clear,
  output logic o_win_end
);

  localparam logic [WIN_W-1:0] LastCnt = WIN_W'(WINDOW_LEN - 1);

  logic [WIN_W-1:0] r_win_cnt;

  assign o_win_end = i_run && (r_win_cnt == LastCnt);

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_win_cnt <= '0;
    end else if (i_run) begin
      r_win_cnt <= o_win_end ? '0 : r_win_cnt + WIN_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_monitor.sv
// Counts detector pulses per fixed window and reports each window's count through a
// valid/ready port, with a saturating lifetime total and a sticky overrun flag.
module seq_detect_monitor
  import seq_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TOT_W      = 16,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned WINDOW_LEN = 1000,
  parameter int unsigned THRESH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_det_in,
  input  logic             i_res_ready,
  input  logic             i_clr_ovr,
  output logic             o_res_valid,
  output logic [CNT_W-1:0] o_res_count,
  output logic             o_res_alarm,
  output logic [TOT_W-1:0] o_total_cnt,
  output logic             o_ovr,
  output logic             o_busy
);

  state_e           r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_win_acc,   w_win_acc_nxt;
  logic [TOT_W-1:0] r_total,     w_total_nxt;
  logic [CNT_W-1:0] r_res_count, w_res_count_nxt;
  logic             r_res_alarm, w_res_alarm_nxt;
  logic             r_res_valid, w_res_valid_nxt;
  logic             r_ovr,       w_ovr_nxt;

  logic             w_run;
  logic             w_win_end;
  logic [CNT_W-1:0] w_acc_sum;

  // Timer only advances while enabled in RUN; a disabled cycle suppresses any window end.
  assign w_run = (r_state == RUN) && i_en;

  window_timer #(
    .WIN_W     (WIN_W),
    .WINDOW_LEN(WINDOW_LEN)
  ) u_window_timer (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_clear  (r_state == IDLE),
    .o_win_end(w_win_end)
  );

  assign w_acc_sum = CNT_W'(sat_inc(32'(r_win_acc), i_det_in, CNT_W));

  always_comb begin
    w_state_nxt     = r_state;
    w_win_acc_nxt   = r_win_acc;
    w_total_nxt     = r_total;
    w_res_count_nxt = r_res_count;
    w_res_alarm_nxt = r_res_alarm;
    w_res_valid_nxt = r_res_valid && !i_res_ready;
    w_ovr_nxt       = r_ovr && !i_clr_ovr;

    unique case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_nxt   = RUN;
          w_win_acc_nxt = '0;
        end
      end
      RUN: begin
        w_total_nxt = TOT_W'(sat_inc(32'(r_total), i_det_in, TOT_W));
        if (!i_en) begin
          w_state_nxt   = IDLE;
          w_win_acc_nxt = '0;
        end else if (w_win_end) begin
          w_res_count_nxt = w_acc_sum;
          w_res_alarm_nxt = (w_acc_sum >= CNT_W'(THRESH));
          w_res_valid_nxt = 1'b1;
          w_win_acc_nxt   = '0;
          // Overwriting an unaccepted result; set takes priority over clear.
          if (r_res_valid && !i_res_ready) w_ovr_nxt = 1'b1;
        end else begin
          w_win_acc_nxt = w_acc_sum;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_win_acc   <= '0;
      r_total     <= '0;
      r_res_count <= '0;
      r_res_alarm <= 1'b0;
      r_res_valid <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_win_acc   <= w_win_acc_nxt;
      r_total     <= w_total_nxt;
      r_res_count <= w_res_count_nxt;
      r_res_alarm <= w_res_alarm_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_ovr       <= w_ovr_nxt;
    end
  end

  assign o_res_valid = r_res_valid;
  assign o_res_count = r_res_count;
  assign o_res_alarm = r_res_alarm;
  assign o_total_cnt = r_total;
  assign o_ovr       = r_ovr;
  assign o_busy      = (r_state == RUN);

endmodule

// File: tb/tb_seq_detect_monitor.sv
// Bench for seq_detect_monitor: directed vector table, corner sequences, random vs. model.
module tb_seq_detect_monitor;

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned TOT_W  = 16;
  localparam int unsigned WL     = 8;
  localparam int unsigned TH     = 2;
  localparam int          CNTMAX = 7;
  localparam int          TOTMAX = 65535;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0, det = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic             o_res_valid, o_res_alarm, o_ovr, o_busy;
  logic [CNT_W-1:0] o_res_count;
  logic [TOT_W-1:0] o_total_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: window position plus an unbounded per-window sum, saturated on report.
  bit m_run, m_valid, m_alarm, m_ovr;
  int m_pos, m_wsum, m_total, m_count;

  seq_detect_monitor #(
    .CNT_W     (CNT_W),
    .TOT_W     (TOT_W),
    .WIN_W     (16),
    .WINDOW_LEN(WL),
    .THRESH    (TH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (en),
    .i_det_in   (det),
    .i_res_ready(rdy),
    .i_clr_ovr  (clr),
    .o_res_valid(o_res_valid),
    .o_res_count(o_res_count),
    .o_res_alarm(o_res_alarm),
    .o_total_cnt(o_total_cnt),
    .o_ovr      (o_ovr),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_alarm = 0; m_ovr = 0;
    m_pos = 0; m_wsum = 0; m_total = 0; m_count = 0;
  endtask

  task automatic model_update(input bit e, input bit d, input bit r, input bit c);
    bit nv, novr;
    int s;
    nv   = m_valid && !r;
    novr = m_ovr && !c;
    if (!m_run) begin
      if (e) begin
        m_run = 1; m_pos = 0; m_wsum = 0;
      end
    end else begin
      m_total = imin(m_total + int'(d), TOTMAX);
      if (!e) begin
        m_run = 0;
      end else if (m_pos == WL - 1) begin
        s = imin(m_wsum + int'(d), CNTMAX);
        if (m_valid && !r) novr = 1;
        m_count = s;
        m_alarm = (s >= TH);
        nv      = 1;
        m_pos   = 0;
        m_wsum  = 0;
      end else begin
        m_pos++;
        m_wsum += int'(d);
      end
    end
    m_valid = nv;
    m_ovr   = novr;
  endtask

  task automatic compare_model();
    chk("res_valid", 32'(o_res_valid), 32'(m_valid));
    chk("res_count", 32'(o_res_count), 32'(m_count));
    chk("res_alarm", 32'(o_res_alarm), 32'(m_alarm));
    chk("total_cnt", 32'(o_total_cnt), 32'(m_total));
    chk("ovr",       32'(o_ovr),       32'(m_ovr));
    chk("busy",      32'(o_busy),      32'(m_run));
  endtask

  task automatic step(input bit e, input bit d, input bit r, input bit c);
    en = e; det = d; rdy = r; clr = c;
    @(posedge clk);
    model_update(e, d, r, c);
    #1;
    compare_model();
  endtask

  // Reset with every other input active to show rst overrides them.
  task automatic do_reset(input int n);
    rst = 1; en = 1; det = 1; rdy = 0; clr = 0;
    repeat (n) @(posedge clk);
    model_reset();
    #1;
    rst = 0;
    compare_model();
  endtask

  // Leave RUN (if there) and re-enter so the next step is window cycle 0.
  task automatic align(input bit r);
    step(0, 0, r, 0);
    step(1, 0, r, 0);
  endtask

  task automatic window(input logic [7:0] pat, input bit r);
    for (int i = 0; i < 8; i++) step(1, pat[i], r, 0);
  endtask

  typedef struct {
    logic en, det, rdy, clr;
    logic exp_valid;
    int   exp_count;
    logic exp_alarm;
    int   exp_total;
    logic exp_ovr;
    logic exp_busy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Basic window: enter RUN, pulses at window cycles 1, 4, 7, then one more cycle.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 2, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1, 3, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b1, 3, 1'b0, 1'b1};

    model_reset();
    do_reset(2);
    chk("reset_valid", 32'(o_res_valid), 32'd0);
    chk("reset_total", 32'(o_total_cnt), 32'd0);
    chk("reset_busy",  32'(o_busy),      32'd0);

    // Idle: det pulses ignored while disabled.
    for (int i = 0; i < 20; i++) step(0, i[0], 1, 0);
    chk("idle_total", 32'(o_total_cnt), 32'd0);
    chk("idle_busy",  32'(o_busy),      32'd0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].en, vecs[i].det, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(o_res_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_count", i), 32'(o_res_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_alarm", i), 32'(o_res_alarm), 32'(vecs[i].exp_alarm));
      chk($sformatf("vec%0d_total", i), 32'(o_total_cnt), 32'(vecs[i].exp_total));
      chk($sformatf("vec%0d_ovr",   i), 32'(o_ovr),       32'(vecs[i].exp_ovr));
      chk($sformatf("vec%0d_busy",  i), 32'(o_busy),      32'(vecs[i].exp_busy));
    end

    // Below threshold with backpressure: result held until accepted.
    align(1);
    window(8'b0000_0010, 0);
    chk("bp_valid", 32'(o_res_valid), 32'd1);
    chk("bp_count", 32'(o_res_count), 32'd1);
    chk("bp_alarm", 32'(o_res_alarm), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      chk("bp_hold_valid", 32'(o_res_valid), 32'd1);
      chk("bp_hold_count", 32'(o_res_count), 32'd1);
    end
    step(1, 0, 1, 0);
    chk("bp_accept", 32'(o_res_valid), 32'd0);

    // Overrun, clear, and set-beats-clear.
    align(0);
    window(8'b0100_0100, 0);
    chk("ovr_first_count", 32'(o_res_count), 32'd2);
    chk("ovr_first_ovr",   32'(o_ovr),       32'd0);
    window(8'b1011_0101, 0);
    chk("ovr_set",   32'(o_ovr),       32'd1);
    chk("ovr_count", 32'(o_res_count), 32'd5);
    step(1, 0, 0, 1);
    chk("ovr_clear", 32'(o_ovr), 32'd0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("ovr_set_wins", 32'(o_ovr),       32'd1);
    chk("ovr_third_cnt", 32'(o_res_count), 32'd0);

    // Saturation of window count and lifetime total.
    do_reset(2);
    align(1);
    for (int w = 0; w < 3; w++) begin
      window(8'hFF, 1);
      chk("sat_count", 32'(o_res_count), 32'd7);
      chk("sat_alarm", 32'(o_res_alarm), 32'd1);
    end
    chk("sat_total24", 32'(o_total_cnt), 32'd24);
    for (int i = 0; i < 65530; i++) step(1, 1, 1, 0);
    chk("sat_total_max", 32'(o_total_cnt), 32'd65535);

    // Disable mid-window: partial window discarded, restart from cycle 0.
    do_reset(2);
    align(1);
    step(1, 0, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
    chk("dis_valid", 32'(o_res_valid), 32'd0);
    chk("dis_total", 32'(o_total_cnt), 32'd3);
    chk("dis_busy",  32'(o_busy),      32'd0);
    step(1, 0, 1, 0);
    window(8'b0001_0010, 1);
    chk("dis_new_valid", 32'(o_res_valid), 32'd1);
    chk("dis_new_count", 32'(o_res_count), 32'd2);
    chk("dis_new_total", 32'(o_total_cnt), 32'd5);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else step($urandom_range(0, 15) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
